// File: rtl/load_store_unit.sv
// Load/store unit between the MEM stage and a 64-bit-word DataMemory: read-modify-write for narrow stores,
// lane extraction with sign/zero extension for loads. Define MISALIGN_TRAP_EN to trap misaligned accesses.
module load_store_unit #(
  parameter logic [63:0] MEM_BYTES = 64'd8192
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_store,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [63:0] mem_address,
  output logic [63:0] mem_writeData,
  output logic        mem_MemWrite,
  output logic        mem_MemRead,
  input  logic [63:0] mem_readData
);

  typedef enum logic [2:0] {IDLE, RD, RD_WAIT, WR, RESP} state_t;

  state_t      state_q, state_d;
  logic [60:0] word_addr_q, word_addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] wword_q, wword_d;
  logic [63:0] rdata_q, rdata_d;
  logic [1:0]  size_q, size_d;
  logic [2:0]  lane_q, lane_d;
  logic        unsigned_q, unsigned_d;
  logic        store_q, store_d;
  logic        err_q, err_d;

  logic [2:0]  req_lane;
  logic        req_bad_align;
  logic        req_err;
  logic [5:0]  shamt;
  logic [63:0] size_mask;
  logic [63:0] rd_shifted;
  logic [63:0] load_value;
  logic [63:0] merged_word;

  // Lane bits that must be kept for a given access size.
  function automatic logic [2:0] align_mask(input logic [1:0] size);
    case (size)
      2'b00:   align_mask = 3'b111;
      2'b01:   align_mask = 3'b110;
      2'b10:   align_mask = 3'b100;
      default: align_mask = 3'b000;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  assign req_lane      = req_addr[2:0];
  assign req_bad_align = |(req_addr[2:0] & ~align_mask(req_size));
`else
  assign req_lane      = req_addr[2:0] & align_mask(req_size);
  assign req_bad_align = 1'b0;
`endif

  assign req_err = (req_addr >= MEM_BYTES) || req_bad_align;

  always_comb begin
    shamt      = {lane_q, 3'b000};
    rd_shifted = mem_readData >> shamt;
    size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
    load_value = rd_shifted;
    case (size_q)
      2'b00: begin
        size_mask  = 64'h0000_0000_0000_00FF;
        load_value = {{56{~unsigned_q & rd_shifted[7]}}, rd_shifted[7:0]};
      end
      2'b01: begin
        size_mask  = 64'h0000_0000_0000_FFFF;
        load_value = {{48{~unsigned_q & rd_shifted[15]}}, rd_shifted[15:0]};
      end
      2'b10: begin
        size_mask  = 64'h0000_0000_FFFF_FFFF;
        load_value = {{32{~unsigned_q & rd_shifted[31]}}, rd_shifted[31:0]};
      end
      default: begin
        size_mask  = 64'hFFFF_FFFF_FFFF_FFFF;
        load_value = rd_shifted;
      end
    endcase
    merged_word = (mem_readData & ~(size_mask << shamt)) | ((wdata_q & size_mask) << shamt);
  end

  always_comb begin
    state_d     = state_q;
    word_addr_d = word_addr_q;
    wdata_d     = wdata_q;
    wword_d     = wword_q;
    rdata_d     = rdata_q;
    size_d      = size_q;
    lane_d      = lane_q;
    unsigned_d  = unsigned_q;
    store_d     = store_q;
    err_d       = err_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          word_addr_d = req_addr[63:3];
          wdata_d     = req_wdata;
          size_d      = req_size;
          lane_d      = req_lane;
          unsigned_d  = req_unsigned;
          store_d     = req_store;
          if (req_err) begin
            err_d   = 1'b1;
            rdata_d = 64'd0;
            state_d = RESP;
          end else if (!req_store || req_size != 2'b11) begin
            state_d = RD;
          end else begin
            wword_d = req_wdata;
            state_d = WR;
          end
        end
      end
      RD:      state_d = RD_WAIT;
      RD_WAIT: begin
        // Read data arrives this cycle: either finish the load or merge for the write-back.
        if (store_q) begin
          wword_d = merged_word;
          state_d = WR;
        end else begin
          rdata_d = load_value;
          err_d   = 1'b0;
          state_d = RESP;
        end
      end
      WR: begin
        rdata_d = 64'd0;
        err_d   = 1'b0;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      word_addr_q <= '0;
      wdata_q     <= '0;
      wword_q     <= '0;
      rdata_q     <= '0;
      size_q      <= '0;
      lane_q      <= '0;
      unsigned_q  <= 1'b0;
      store_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_addr_q <= word_addr_d;
      wdata_q     <= wdata_d;
      wword_q     <= wword_d;
      rdata_q     <= rdata_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      unsigned_q  <= unsigned_d;
      store_q     <= store_d;
      err_q       <= err_d;
    end
  end

  assign req_ready     = (state_q == IDLE);
  assign resp_valid    = (state_q == RESP);
  assign resp_rdata    = rdata_q;
  assign resp_err      = err_q;
  assign mem_address   = {word_addr_q, 3'b000};
  assign mem_writeData = wword_q;
  assign mem_MemRead   = (state_q == RD);
  assign mem_MemWrite  = (state_q == WR);

endmodule
